// File: rtl/hps_reset_req_sequencer_if.sv
// Signal bundle between the board keys / HPS handshake and the reset request sequencer.
// The sequencer connects through the slave modport; whatever drives the keys uses master.
interface hps_reset_req_sequencer_if;
    logic [1:0]  button_n;
    logic        enable;
    logic        h2f_reset_n;
    logic        f2h_cold_reset_req_n;
    logic        f2h_warm_reset_req_n;
    logic        f2h_debug_reset_req_n;
    logic [27:0] stm_hwevents;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  button_n,
        input  enable,
        input  h2f_reset_n,
        output f2h_cold_reset_req_n,
        output f2h_warm_reset_req_n,
        output f2h_debug_reset_req_n,
        output stm_hwevents,
        output busy,
        output timeout_err
    );

    modport master (
        output button_n,
        output enable,
        output h2f_reset_n,
        input  f2h_cold_reset_req_n,
        input  f2h_warm_reset_req_n,
        input  f2h_debug_reset_req_n,
        input  stm_hwevents,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/hps_reset_req_sequencer.sv
// Debounces board keys and sequences warm/cold/debug HPS reset requests with handshake wait,
// STM event strobes and a sticky handshake-timeout flag.
module hps_reset_req_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES    = 50000,
    parameter int unsigned LONG_PRESS_CYCLES  = 100000000,
    parameter int unsigned REQ_PULSE_CYCLES   = 1024,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 50000000,
    parameter int unsigned CNT_W              = 32
) (
    input logic                      clk,
    input logic                      reset,
    hps_reset_req_sequencer_if.slave bus
);
    // Compare against N-1 on the pre-increment value so the counters never need to hold N.
    localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LongLast  = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] PulseLast = CNT_W'(REQ_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] AckLast   = CNT_W'(ACK_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StPress, StAssert, StWaitAckLow, StWaitAckHigh, StLockout
    } state_e;

    logic [1:0]       btn_s1_q, btn_s2_q;
    logic             h2f_s1_q, h2f_s2_q;
    logic [1:0]       key_q, key_d;
    logic [CNT_W-1:0] deb_cnt_q [2];
    logic [CNT_W-1:0] deb_cnt_d [2];
    logic [1:0]       press;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cold_q, cold_d;
    logic             dbg_act_q, dbg_act_d;
    logic [CNT_W-1:0] dbg_cnt_q, dbg_cnt_d;

    logic             warm_n_q, warm_n_d, cold_n_q, cold_n_d, dbg_n_q, dbg_n_d;
    logic [4:0]       ev_q, ev_d;
    logic             busy_q, busy_d, terr_q, terr_d;

    always_comb begin
        key_d = key_q;
        press = '0;
        for (int i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            if (btn_s2_q[i] != key_q[i]) begin
                if (deb_cnt_q[i] >= DebLast) begin
                    key_d[i] = btn_s2_q[i];
                    press[i] = ~btn_s2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cold_d    = cold_q;
        terr_d    = terr_q;
        ev_d      = '0;
        dbg_act_d = dbg_act_q;
        dbg_cnt_d = dbg_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (press[0] && bus.enable) begin
                    state_d = StPress;
                    cnt_d   = '0;
                end
            end
            StPress: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (key_q[0]) begin
                    state_d = StAssert;
                    cold_d  = 1'b0;
                    cnt_d   = '0;
                    ev_d[0] = 1'b1;
                end else if (cnt_q >= LongLast) begin
                    state_d = StAssert;
                    cold_d  = 1'b1;
                    cnt_d   = '0;
                    ev_d[1] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StAssert: begin
                if (cnt_q >= PulseLast) begin
                    state_d = StWaitAckLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitAckLow, StWaitAckHigh: begin
                if ((state_q == StWaitAckLow) && !h2f_s2_q) begin
                    state_d = StWaitAckHigh;
                    cnt_d   = '0;
                end else if ((state_q == StWaitAckHigh) && h2f_s2_q) begin
                    state_d = StLockout;
                    ev_d[3] = 1'b1;
                end else if (cnt_q >= AckLast) begin
                    state_d = StLockout;
                    terr_d  = 1'b1;
                    ev_d[4] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StLockout: begin
                if (key_q[0]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Debug pulse runs beside the main FSM; presses mid-pulse or past PRESS are dropped.
        if (press[1] && bus.enable && !dbg_act_q && (state_q == StIdle || state_q == StPress)) begin
            dbg_act_d = 1'b1;
            dbg_cnt_d = '0;
            ev_d[2]   = 1'b1;
        end else if (dbg_act_q) begin
            if (dbg_cnt_q >= PulseLast) dbg_act_d = 1'b0;
            else                        dbg_cnt_d = dbg_cnt_q + CNT_W'(1);
        end

        // Outputs registered from next state so they line up exactly with state_q.
        warm_n_d = !((state_d == StAssert) && !cold_d);
        cold_n_d = !((state_d == StAssert) && cold_d);
        dbg_n_d  = !dbg_act_d;
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1_q     <= 2'b11;
            btn_s2_q     <= 2'b11;
            h2f_s1_q     <= 1'b1;
            h2f_s2_q     <= 1'b1;
            key_q        <= 2'b11;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            state_q      <= StIdle;
            cnt_q        <= '0;
            cold_q       <= 1'b0;
            dbg_act_q    <= 1'b0;
            dbg_cnt_q    <= '0;
            warm_n_q     <= 1'b1;
            cold_n_q     <= 1'b1;
            dbg_n_q      <= 1'b1;
            ev_q         <= '0;
            busy_q       <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            btn_s1_q     <= bus.button_n;
            btn_s2_q     <= btn_s1_q;
            h2f_s1_q     <= bus.h2f_reset_n;
            h2f_s2_q     <= h2f_s1_q;
            key_q        <= key_d;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cold_q       <= cold_d;
            dbg_act_q    <= dbg_act_d;
            dbg_cnt_q    <= dbg_cnt_d;
            warm_n_q     <= warm_n_d;
            cold_n_q     <= cold_n_d;
            dbg_n_q      <= dbg_n_d;
            ev_q         <= ev_d;
            busy_q       <= busy_d;
            terr_q       <= terr_d;
        end
    end

    assign bus.f2h_warm_reset_req_n  = warm_n_q;
    assign bus.f2h_cold_reset_req_n  = cold_n_q;
    assign bus.f2h_debug_reset_req_n = dbg_n_q;
    assign bus.stm_hwevents          = {23'b0, ev_q};
    assign bus.busy                  = busy_q;
    assign bus.timeout_err           = terr_q;
endmodule
